reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, range 1..4, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1, 1 = entry 0 hardwired to zero.
REQ-005 SHALL have port clk  in  1  the single clock, all state on posedge.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  out  NUM_RD*DATA_W  packed read data, same packing.
REQ-009 SHALL have port rd_busy  out  NUM_RD  per-read-port pending-producer flag.
REQ-010 SHALL have ports we0/waddr0/wdata0 and we1/waddr1/wdata1  in  1/ADDR_W/DATA_W  two write ports.
REQ-011 SHALL have ports issue_valid/issue_dst  in  1/ADDR_W  scoreboard set request.
REQ-012 SHALL have port pending_cnt  out  ADDR_W+1  registered count of pending entries.

Function
REQ-013 SHALL drive rd_data combinationally from array contents (asynchronous read), per port independently.
REQ-014 SHALL, when ZERO_REG=1, return 0 and rd_busy=0 for address 0, discard writes to 0, never set pending bit 0.
REQ-015 SHALL write wdataN to waddrN on posedge clk when weN=1 and rstn=1.
REQ-016 SHALL, when we0 and we1 target the same address in one cycle, store wdata1 (port 1 wins).
REQ-017 SHALL keep a pending bit per entry: set on posedge when issue_valid=1 for issue_dst; cleared on posedge by any weN=1 to that address.
REQ-018 SHALL, when set and clear hit the same address in one cycle, leave the bit set (new producer wins).
REQ-019 SHALL drive rd_busy[i] = pending[rd_addr[i]], masked per REQ-014 and REQ-025.
REQ-020 SHALL update pending_cnt on posedge to the population count of the next pending vector; range 0..2**ADDR_W, no wrap.
REQ-021 SHALL ignore issue_valid with issue_dst already pending (bit stays set, count unchanged).

Reset
REQ-022 SHALL, on rstn=0, asynchronously clear all array entries, all pending bits and pending_cnt to 0, independent of clk.
REQ-023 SHALL block writes and issue sets while rstn=0; rd_data reads 0 for all addresses during reset.
REQ-024 SHALL abandon any same-cycle write or issue coinciding with reset assertion; first update occurs on the first posedge after rstn rises.

Configuration
REQ-025 SHALL, with macro REG_FILE_MP_BYPASS_EN defined, forward in-cycle write data to rd_data on address match (priority wdata1 > wdata0 > array) and force rd_busy[i]=0 on such a match.
REQ-026 SHALL, without REG_FILE_MP_BYPASS_EN, return array contents only (new data visible cycle after write) and rd_busy from pending bits unmodified.

Verification
REQ-027 SHALL cover: reset, then read all addresses on all ports -> rd_data=0, rd_busy=0, pending_cnt=0.
REQ-028 SHALL cover: we0=1 waddr0=3 wdata0=0x11, we1=1 waddr1=3 wdata1=0x22 same cycle -> next cycle rd_addr=3 returns 0x22.
REQ-029 SHALL cover: we0=1 waddr0=0 wdata0=0xFFFF_FFFF, ZERO_REG=1 -> rd_addr=0 returns 0; issue_dst=0 -> pending_cnt stays 0.
REQ-030 SHALL cover: issue_valid dst=5, next cycle rd_busy=1 and pending_cnt=1; then we1 waddr1=5 and issue_valid dst=5 same cycle -> bit stays set, pending_cnt=1.
REQ-031 SHALL cover: reg 7 pending, we0 waddr0=7 wdata0=0xABCD with rd_addr=7 same cycle -> with BYPASS_EN rd_data=0xABCD, rd_busy=0; without, old value and rd_busy=1.
REQ-032 SHALL cover: entries 1..4 pending, rstn pulsed low between clock edges -> all pending and data cleared immediately, pending_cnt=0 before next posedge.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-read-port register file with a per-entry
// pending-producer scoreboard.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width, depth = 2**ADDR_W
//   NUM_RD   number of read ports (1..4)
//   ZERO_REG 1 = entry 0 reads as zero, is never written, never pending
//
// Ports:
//   clk          single clock, all state updates on posedge
//   rstn         asynchronous active-low reset, clears data, pending bits and count
//   rd_addr      packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      packed read data (combinational), same packing
//   rd_busy      per-read-port "entry has an outstanding producer" flag
//   we0/waddr0/wdata0, we1/waddr1/wdata1
//                two write ports; port 1 wins on an address collision.
//                Any write clears the pending bit of its address.
//   issue_valid/issue_dst
//                marks issue_dst as pending (a new producer is in flight)
//   pending_cnt  registered number of pending entries
//
// Optional feature: define REG_FILE_MP_BYPASS_EN to forward same-cycle write
// data to the read ports (wdata1 > wdata0 > array) and report not-busy on
// such a forwarded read. Without it, reads see the array only.

module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_dst,
    output logic [ADDR_W:0]          pending_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    // Storage is flops rather than block RAM: the whole array must clear
    // asynchronously on reset and every read port is combinational.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Next-state for data, pending bits and the pending count.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        cnt_d  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!(ZERO_REG != 0 && e == 0)) begin
                if (we1 && waddr1 == ADDR_W'(e)) begin
                    mem_d[e] = wdata1;
                end else if (we0 && waddr0 == ADDR_W'(e)) begin
                    mem_d[e] = wdata0;
                end
                if ((we0 && waddr0 == ADDR_W'(e)) || (we1 && waddr1 == ADDR_W'(e))) begin
                    pend_d[e] = 1'b0;
                end
                // Set is applied after clear: a newly issued producer
                // outranks the write retiring the previous one.
                if (issue_valid && issue_dst == ADDR_W'(e)) begin
                    pend_d[e] = 1'b1;
                end
            end
        end
        // Count the next vector so pending_cnt lines up with pend_q.
        for (int e = 0; e < DEPTH; e++) begin
            cnt_d = cnt_d + CNT_W'(pend_d[e]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    // Read ports, each fully independent.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[addr];
            busy = pend_q[addr];
`ifdef REG_FILE_MP_BYPASS_EN
            // Forwarding is suppressed in reset so reads stay at zero.
            if (rstn) begin
                if (we1 && waddr1 == addr) begin
                    data = wdata1;
                    busy = 1'b0;
                end else if (we0 && waddr0 == addr) begin
                    data = wdata0;
                    busy = 1'b0;
                end
            end
`endif
            if (ZERO_REG != 0 && addr == '0) begin
                data = '0;
                busy = 1'b0;
            end
            if (!rstn) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data;
        assign rd_busy[gi]                  = busy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: directed scenarios plus randomized traffic
// checked against a behavioural model (plain arrays updated by the
// register-file rules). Adapts its expectations to REG_FILE_MP_BYPASS_EN.

module tb_reg_file_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we0 = 1'b0;
    logic [ADDR_W-1:0]        waddr0 = '0;
    logic [DATA_W-1:0]        wdata0 = '0;
    logic                     we1 = 1'b0;
    logic [ADDR_W-1:0]        waddr1 = '0;
    logic [DATA_W-1:0]        wdata1 = '0;
    logic                     issue_valid = 1'b0;
    logic [ADDR_W-1:0]        issue_dst = '0;
    logic [ADDR_W:0]          pending_cnt;

    reg_file_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and set of pending entries.
    logic [DATA_W-1:0] m_mem  [DEPTH];
    bit                m_pend [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) begin
            m_mem[e]  = '0;
            m_pend[e] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int e = 0; e < DEPTH; e++) n += int'(m_pend[e]);
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int a);
        if (!rstn || a == 0) return '0;
`ifdef REG_FILE_MP_BYPASS_EN
        if (we1 && int'(waddr1) == a) return wdata1;
        if (we0 && int'(waddr0) == a) return wdata0;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (!rstn || a == 0) return 1'b0;
`ifdef REG_FILE_MP_BYPASS_EN
        if ((we1 && int'(waddr1) == a) || (we0 && int'(waddr0) == a)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    // Commit one clock edge of the current inputs into the model.
    task automatic model_edge();
        if (!rstn) return;
        if (we0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
        if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
        if (issue_valid && issue_dst != 0) m_pend[issue_dst] = 1'b1;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic check_ports(input string tag);
        for (int p = 0; p < NUM_RD; p++) begin
            int a;
            a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
            check({tag, "_data"}, 64'(rd_data[p*DATA_W +: DATA_W]), 64'(exp_data(a)));
            check({tag, "_busy"}, 64'(rd_busy[p]), 64'(exp_busy(a)));
        end
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0;
    endtask

    // Called just after a negedge with inputs applied: check the
    // combinational reads, take one posedge, check the registered count.
    task automatic cycle(input string tag);
        #1;
        check_ports(tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_cnt"}, 64'(pending_cnt), 64'(model_count()));
        $display("%s we0=%0b a0=%0d d0=%0h we1=%0b a1=%0d d1=%0h iss=%0b dst=%0d cnt=%0d",
                 tag, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_valid, issue_dst, pending_cnt);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        // Reset held: everything reads zero on all ports.
        repeat (2) @(negedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            for (int p = 0; p < NUM_RD; p++) set_rd(p, (a + p) % DEPTH);
            #1;
            check_ports("reset_read");
        end
        check("reset_cnt", 64'(pending_cnt), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        for (int a = 0; a < DEPTH; a += 4) begin
            for (int p = 0; p < NUM_RD; p++) set_rd(p, a + p);
            #1;
            check_ports("post_reset_read");
        end

        // Write collision: port 1 wins.
        we0 = 1; waddr0 = 3; wdata0 = 32'h11; we1 = 1; waddr1 = 3; wdata1 = 32'h22;
        set_rd(0, 3); set_rd(1, 3);
        cycle("collide");
        idle();
        #1;
        check("collide_rd", 64'(rd_data[DATA_W-1:0]), 64'h22);

        // Entry 0 is hardwired and never pending.
        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF; issue_valid = 1; issue_dst = 0;
        set_rd(0, 0); set_rd(1, 0);
        cycle("zero_reg");
        idle();
        #1;
        check("zero_rd", 64'(rd_data[DATA_W-1:0]), 64'h0);
        check("zero_cnt", 64'(pending_cnt), 64'd0);

        // Issue then clear-and-reissue in one cycle: bit stays set.
        issue_valid = 1; issue_dst = 5; set_rd(0, 5); set_rd(1, 5);
        cycle("issue5");
        idle();
        #1;
        check("issue5_busy", 64'(rd_busy[0]), 64'd1);
        check("issue5_cnt", 64'(pending_cnt), 64'd1);
        we1 = 1; waddr1 = 5; wdata1 = 32'h55; issue_valid = 1; issue_dst = 5;
        cycle("reissue5");
        idle();
        #1;
        check("reissue5_cnt", 64'(pending_cnt), 64'd1);
        check("reissue5_busy", 64'(rd_busy[1]), 64'd1);

        // Read of a pending entry in the same cycle it is written.
        issue_valid = 1; issue_dst = 7;
        cycle("issue7");
        idle();
        we0 = 1; waddr0 = 7; wdata0 = 32'hABCD; set_rd(0, 7); set_rd(1, 5);
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        check("bypass7_data", 64'(rd_data[DATA_W-1:0]), 64'hABCD);
        check("bypass7_busy", 64'(rd_busy[0]), 64'd0);
`else
        check("bypass7_data", 64'(rd_data[DATA_W-1:0]), 64'h0);
        check("bypass7_busy", 64'(rd_busy[0]), 64'd1);
`endif
        cycle("write7");
        idle();
        #1;
        check("write7_after", 64'(rd_data[DATA_W-1:0]), 64'hABCD);

        // Randomized traffic, addresses biased toward a small range.
        for (int i = 0; i < 400; i++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            waddr0 = ADDR_W'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
            waddr1 = ADDR_W'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
            wdata0 = $urandom;
            wdata1 = $urandom;
            issue_valid = ($urandom_range(0, 9) < 5);
            issue_dst = ADDR_W'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
            for (int p = 0; p < NUM_RD; p++) begin
                case ($urandom_range(0, 3))
                    0: set_rd(p, int'(waddr0));
                    1: set_rd(p, int'(waddr1));
                    default: set_rd(p, $urandom_range(0, DEPTH - 1));
                endcase
            end
            cycle("rand");
        end
        idle();

        // Entries 1..4 pending with data, then reset pulsed mid-cycle.
        for (int a = 1; a <= 4; a++) begin
            we0 = 1; waddr0 = ADDR_W'(a); wdata0 = 32'h100 + 32'(a);
            issue_valid = 1; issue_dst = ADDR_W'(a);
            cycle("fill");
        end
        idle();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("async_cnt", 64'(pending_cnt), 64'd0);
        for (int a = 1; a <= 4; a += 2) begin
            set_rd(0, a); set_rd(1, a + 1);
            #1;
            check_ports("async_read");
        end
        // Writes and issues while in reset are ignored.
        we1 = 1; waddr1 = 9; wdata1 = 32'hDEAD; issue_valid = 1; issue_dst = 9;
        set_rd(0, 9); set_rd(1, 9);
        cycle("in_reset");
        idle();
        rstn = 1'b1;
        #1;
        check("after_reset_data", 64'(rd_data[DATA_W-1:0]), 64'h0);
        check("after_reset_busy", 64'(rd_busy[0]), 64'd0);
        check("after_reset_cnt", 64'(pending_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
